// File: rtl/frame_path_scheduler_pkg.sv
// rtl/frame_path_scheduler_pkg.sv - shared state encodings and sizing helpers for the frame path scheduler
package frame_path_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_META    = 2'd1,
    ST_FCNT    = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_path_scheduler_if.sv
// rtl/frame_path_scheduler_if.sv - stream bundle shared by payload, metadata and output paths
interface frame_path_scheduler_if #(
  parameter int DW = 128
);
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [DW/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/frame_path_scheduler_axis_out_slot.sv
// rtl/frame_path_scheduler_axis_out_slot.sv - one-deep registered stream output slot
module axis_out_slot #(
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DW-1:0]   load_data,
  input  logic            load_last,
  output logic            free,
  output logic [DW-1:0]   tdata,
  output logic            tvalid,
  output logic            tlast,
  output logic [DW/8-1:0] tkeep,
  input  logic            tready
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  // The slot can take a new beat when empty or when its current beat leaves this cycle.
  assign free   = !valid_q || tready;
  assign tdata  = data_q;
  assign tvalid = valid_q;
  assign tlast  = last_q;
  assign tkeep  = {(DW/8){valid_q}};

  // Next-state: a stalled beat stays frozen; otherwise take the offered beat or go empty.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (free) begin
      valid_d = load;
      if (load) begin
        data_d = load_data;
        last_d = load_last;
      end
    end
  end

  // Slot registers; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/frame_path_scheduler.sv
// rtl/frame_path_scheduler.sv - ping-pong payload packets over two paths, then broadcast metadata and frame count
module frame_path_scheduler
  import frame_path_scheduler_pkg::*;
#(
  parameter int DW          = 128,
  parameter int PACKET_SIZE = 2,
  parameter int PP_GROUP    = 2,
  parameter int FRAME_SIZE  = 256,
  parameter int META_LEN    = 2,
  parameter int CW          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  md_enable,
  frame_path_scheduler_if.slave  s_pkt,
  frame_path_scheduler_if.slave  s_meta,
  frame_path_scheduler_if.master m1,
  frame_path_scheduler_if.master m2,
  output logic [1:0]            fsm_state,
  output logic                  active_path,
  output logic [CW-1:0]         frame_count
);

  localparam int BW = cnt_w(PACKET_SIZE);
  localparam int GW = cnt_w(PP_GROUP);
  localparam int FW = cnt_w(FRAME_SIZE);
  localparam int MW = cnt_w(META_LEN);

  if (FRAME_SIZE % PACKET_SIZE != 0) begin : g_bad_frame
    $error("FRAME_SIZE must be a multiple of PACKET_SIZE");
  end
  if (CW > DW) begin : g_bad_cw
    $error("CW must not exceed DW");
  end
  if (PACKET_SIZE < 1 || PP_GROUP < 1 || META_LEN < 1) begin : g_bad_len
    $error("PACKET_SIZE, PP_GROUP and META_LEN must be at least 1");
  end

  state_e        state_q, state_d;
  logic          path_q, path_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [FW-1:0] fbeat_q, fbeat_d;
  logic [MW-1:0] mbeat_q, mbeat_d;

  logic          free1, free2, load1, load2;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          pkt_rdy, meta_rdy, pkt_fire, meta_fire, fcnt_go;
  logic          pkt_last, grp_last, frame_last, meta_last;

  assign pkt_rdy    = (state_q == ST_PAYLOAD) && (path_q ? free2 : free1);
  assign meta_rdy   = (state_q == ST_META) && free1 && free2;
  assign pkt_fire   = s_pkt.tvalid && pkt_rdy;
  assign meta_fire  = s_meta.tvalid && meta_rdy;
  assign fcnt_go    = (state_q == ST_FCNT) && free1 && free2;
  assign pkt_last   = (beat_q == BW'(PACKET_SIZE - 1));
  assign grp_last   = (grp_q == GW'(PP_GROUP - 1));
  assign frame_last = (fbeat_q == FW'(FRAME_SIZE - 1));
  assign meta_last  = (mbeat_q == MW'(META_LEN - 1));

  assign s_pkt.tready  = pkt_rdy;
  assign s_meta.tready = meta_rdy;
  assign fsm_state     = state_q;
  assign active_path   = path_q;
  assign frame_count   = fcnt_q;

  // Output steering: payload goes to the active path only; metadata and frame count go to both together.
  always_comb begin
    load1   = (pkt_fire && !path_q) || meta_fire || fcnt_go;
    load2   = (pkt_fire && path_q) || meta_fire || fcnt_go;
    ld_data = '0;
    ld_last = 1'b0;
    case (state_q)
      ST_PAYLOAD: begin
        ld_data = s_pkt.tdata;
        ld_last = pkt_last;
      end
      ST_META: begin
        ld_data = s_meta.tdata;
        ld_last = meta_last;
      end
      ST_FCNT: begin
        ld_data = DW'(fcnt_q);
        ld_last = 1'b1;
      end
      default: begin
        ld_data = '0;
        ld_last = 1'b0;
      end
    endcase
  end

  // Sequencing: packet/group/frame counters in payload, beat counter in metadata, wrap-up in frame count.
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    fcnt_d  = fcnt_q;
    beat_d  = beat_q;
    grp_d   = grp_q;
    fbeat_d = fbeat_q;
    mbeat_d = mbeat_q;
    case (state_q)
      ST_PAYLOAD: begin
        if (pkt_fire) begin
          beat_d  = pkt_last ? '0 : beat_q + 1'b1;
          fbeat_d = fbeat_q + 1'b1;
          if (pkt_last) begin
            grp_d = grp_last ? '0 : grp_q + 1'b1;
            if (grp_last) path_d = !path_q;
          end
          // Frame end overrides a coincident path toggle so the next frame starts on path 1.
          if (frame_last) begin
            state_d = md_enable ? ST_META : ST_FCNT;
            beat_d  = '0;
            grp_d   = '0;
            fbeat_d = '0;
            path_d  = 1'b0;
          end
        end
      end
      ST_META: begin
        if (meta_fire) begin
          mbeat_d = meta_last ? '0 : mbeat_q + 1'b1;
          if (meta_last) state_d = ST_FCNT;
        end
      end
      ST_FCNT: begin
        if (fcnt_go) begin
          fcnt_d  = fcnt_q + 1'b1;
          path_d  = 1'b0;
          beat_d  = '0;
          grp_d   = '0;
          fbeat_d = '0;
          mbeat_d = '0;
          state_d = ST_PAYLOAD;
        end
      end
      default: state_d = ST_PAYLOAD;
    endcase
  end

  // Scheduler state registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PAYLOAD;
      path_q  <= 1'b0;
      fcnt_q  <= '0;
      beat_q  <= '0;
      grp_q   <= '0;
      fbeat_q <= '0;
      mbeat_q <= '0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      fcnt_q  <= fcnt_d;
      beat_q  <= beat_d;
      grp_q   <= grp_d;
      fbeat_q <= fbeat_d;
      mbeat_q <= mbeat_d;
    end
  end

  axis_out_slot #(.DW(DW)) u_slot1 (
    .clk(clk), .reset(reset), .load(load1), .load_data(ld_data), .load_last(ld_last),
    .free(free1), .tdata(m1.tdata), .tvalid(m1.tvalid), .tlast(m1.tlast), .tkeep(m1.tkeep),
    .tready(m1.tready)
  );

  axis_out_slot #(.DW(DW)) u_slot2 (
    .clk(clk), .reset(reset), .load(load2), .load_data(ld_data), .load_last(ld_last),
    .free(free2), .tdata(m2.tdata), .tvalid(m2.tvalid), .tlast(m2.tlast), .tkeep(m2.tkeep),
    .tready(m2.tready)
  );

endmodule
